// File: rtl/bp_be_fe_queue_ckpt_pkg.sv
// Shared configuration for the checkpointed FE queue.
// Provides the processor-config widths that size an FE queue packet, and a
// helper that derives the packet width from them.
package bp_be_fe_queue_ckpt_pkg;

   localparam int vaddr_width_p               = 39;
   localparam int branch_metadata_fwd_width_p = 36;

   // Packet = message type (2) + PC + 32-bit instruction + branch metadata.
   function automatic int fe_queue_width(input int vaddr_w, input int md_w);
      return 2 + vaddr_w + 32 + md_w;
   endfunction

   localparam int fe_queue_width_lp =
      fe_queue_width(vaddr_width_p, branch_metadata_fwd_width_p);

endpackage

// File: rtl/bp_be_fe_queue_ckpt_ptr.sv
// Wrap-bit pointer for the checkpointed FE queue.
// The MSB is the wrap bit; the low bits index storage.
// Ports:
//    clk_i, reset_n_i  clock and async active-low reset
//    inc_en_i          advance the pointer by one
//    load_en_i         load load_val_i (takes priority over inc_en_i)
//    load_val_i        value to load
//    ptr_o             current pointer value
module bp_be_fe_queue_ckpt_ptr #(
   parameter int ptr_width_p = 5
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   inc_en_i,
   input  logic                   load_en_i,
   input  logic [ptr_width_p-1:0] load_val_i,
   output logic [ptr_width_p-1:0] ptr_o
);

   // NOTE: state registers use non-blocking assignments so every pointer
   // samples the pre-edge values of the others, whatever the block order.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)     ptr_o <= '0;
      else if (load_en_i) ptr_o <= load_val_i;
      else if (inc_en_i)  ptr_o <= ptr_o + 1'b1;
   end

endmodule

// File: rtl/bp_be_fe_queue_ckpt.sv
// Checkpointed circular FIFO between the FE and the BE scheduler.
// Packets stay held until committed (deq), so issued-but-uncommitted packets
// can be replayed by rewinding the read pointer to the commit pointer (roll).
// Ports:
//    clk_i, reset_n_i             clock and async active-low reset
//    fe_queue_i / fe_queue_v_i    FE packet and valid
//    fe_queue_ready_o             space available (not full)
//    fe_queue_o / fe_queue_v_o    packet at read pointer and its valid
//    fe_queue_yumi_i              speculative consume, advances read pointer
//    fe_queue_clr_i               flush all entries
//    fe_queue_roll_i              rewind read pointer to commit pointer
//    fe_queue_deq_i               commit oldest issued entry
//    empty_o                      nothing held at all
module bp_be_fe_queue_ckpt
   import bp_be_fe_queue_ckpt_pkg::*;
#(
   parameter int els_p       = 16,
   parameter int queue_width = fe_queue_width_lp
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic [queue_width-1:0] fe_queue_i,
   input  logic                   fe_queue_v_i,
   output logic                   fe_queue_ready_o,
   output logic [queue_width-1:0] fe_queue_o,
   output logic                   fe_queue_v_o,
   input  logic                   fe_queue_yumi_i,
   input  logic                   fe_queue_clr_i,
   input  logic                   fe_queue_roll_i,
   input  logic                   fe_queue_deq_i,
   output logic                   empty_o
);

   localparam int lg_els_lp = $clog2(els_p);
   localparam int ptr_w_lp  = lg_els_lp + 1;

   logic [ptr_w_lp-1:0] wptr, rptr, cptr;
   logic [ptr_w_lp-1:0] rptr_load_val;
   logic                full;
   logic                enq_fire, yumi_fire, deq_fire, rptr_load;

   // Status is decoded from registered pointers only.
   assign full = (wptr[lg_els_lp-1:0] == cptr[lg_els_lp-1:0])
              && (wptr[lg_els_lp] != cptr[lg_els_lp]);
   assign fe_queue_ready_o = ~full;
   assign fe_queue_v_o     = (rptr != wptr);
   assign empty_o          = (cptr == wptr);

   // clr overrides everything, including a same-cycle enqueue.
   // roll overrides yumi only; deq and enq still apply.
   // Illegal yumi/deq requests are masked so state never goes inconsistent.
   assign enq_fire  = fe_queue_v_i & fe_queue_ready_o & ~fe_queue_clr_i;
   assign yumi_fire = fe_queue_yumi_i & fe_queue_v_o & ~fe_queue_clr_i & ~fe_queue_roll_i;
   assign deq_fire  = fe_queue_deq_i & (cptr != rptr) & ~fe_queue_clr_i;
   assign rptr_load = fe_queue_clr_i | fe_queue_roll_i;
   // On roll the read pointer follows the commit pointer's post-deq value.
   assign rptr_load_val = fe_queue_clr_i ? wptr : (cptr + ptr_w_lp'(deq_fire));

   bp_be_fe_queue_ckpt_ptr #(.ptr_width_p(ptr_w_lp)) wptr_u (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .inc_en_i  (enq_fire),
      .load_en_i (1'b0),
      .load_val_i('0),
      .ptr_o     (wptr)
   );

   bp_be_fe_queue_ckpt_ptr #(.ptr_width_p(ptr_w_lp)) rptr_u (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .inc_en_i  (yumi_fire),
      .load_en_i (rptr_load),
      .load_val_i(rptr_load_val),
      .ptr_o     (rptr)
   );

   bp_be_fe_queue_ckpt_ptr #(.ptr_width_p(ptr_w_lp)) cptr_u (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .inc_en_i  (deq_fire),
      .load_en_i (fe_queue_clr_i),
      .load_val_i(wptr),
      .ptr_o     (cptr)
   );

   // 1W1R storage: synchronous write, asynchronous read.
   logic [queue_width-1:0] mem [els_p];

   // NOTE: storage has no reset; contents are don't-care until written and
   // the read data is only meaningful while fe_queue_v_o is high.
   always_ff @(posedge clk_i) begin
      if (enq_fire) mem[wptr[lg_els_lp-1:0]] <= fe_queue_i;
   end

   assign fe_queue_o = mem[rptr[lg_els_lp-1:0]];

   // Protocol and pointer-ordering checks.
   logic [ptr_w_lp-1:0] occ_rc, occ_wr, occ_wc;
   assign occ_rc = rptr - cptr;
   assign occ_wr = wptr - rptr;
   assign occ_wc = wptr - cptr;

   yumi_legal_a : assert property (@(posedge clk_i) disable iff (!reset_n_i)
      fe_queue_yumi_i |-> fe_queue_v_o);
   deq_legal_a : assert property (@(posedge clk_i) disable iff (!reset_n_i)
      fe_queue_deq_i |-> (cptr != rptr));
   order_a : assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (({1'b0, occ_rc} + {1'b0, occ_wr}) == {1'b0, occ_wc})
      && (occ_wc <= ptr_w_lp'(els_p)));

endmodule

// File: tb/tb_bp_be_fe_queue_ckpt.sv
module tb_bp_be_fe_queue_ckpt;
   import bp_be_fe_queue_ckpt_pkg::*;

   localparam int ELS = 16;
   localparam int W   = fe_queue_width_lp;

   logic         clk = 1'b0;
   logic         reset_n_i;
   logic [W-1:0] fe_queue_i;
   logic         fe_queue_v_i, fe_queue_ready_o, fe_queue_v_o;
   logic [W-1:0] fe_queue_o;
   logic         fe_queue_yumi_i, fe_queue_clr_i, fe_queue_roll_i, fe_queue_deq_i;
   logic         empty_o;

   always #5 clk = ~clk;

   bp_be_fe_queue_ckpt #(.els_p(ELS)) dut (
      .clk_i           (clk),
      .reset_n_i       (reset_n_i),
      .fe_queue_i      (fe_queue_i),
      .fe_queue_v_i    (fe_queue_v_i),
      .fe_queue_ready_o(fe_queue_ready_o),
      .fe_queue_o      (fe_queue_o),
      .fe_queue_v_o    (fe_queue_v_o),
      .fe_queue_yumi_i (fe_queue_yumi_i),
      .fe_queue_clr_i  (fe_queue_clr_i),
      .fe_queue_roll_i (fe_queue_roll_i),
      .fe_queue_deq_i  (fe_queue_deq_i),
      .empty_o         (empty_o)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference model: every held packet in age order, plus how many of
   // them (from the oldest) have been issued but not committed.
   logic [W-1:0] held[$];
   int           issued;

   task automatic model_step(input logic v, input logic [W-1:0] d,
                             input logic yumi, input logic clr,
                             input logic roll, input logic deq);
      bit can_enq, can_yumi, can_deq;
      can_enq  = v && (held.size() < ELS);
      can_yumi = yumi && (issued < held.size()) && !roll;
      can_deq  = deq && (issued > 0);
      if (clr) begin
         held.delete();
         issued = 0;
      end else begin
         if (can_deq) begin
            void'(held.pop_front());
            issued--;
         end
         if (roll)          issued = 0;
         else if (can_yumi) issued++;
         if (can_enq) held.push_back(d);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".ready"}, 128'(fe_queue_ready_o), 128'(held.size() < ELS));
      check({tag, ".v"},     128'(fe_queue_v_o),     128'(issued < held.size()));
      check({tag, ".empty"}, 128'(empty_o),          128'(held.size() == 0));
      if (issued < held.size())
         check({tag, ".data"}, 128'(fe_queue_o), 128'(held[issued]));
   endtask

   // One clock: drive inputs, advance the model, sample #1 after the edge.
   task automatic cycle(input string tag, input logic v, input logic [W-1:0] d,
                        input logic yumi, input logic clr,
                        input logic roll, input logic deq);
      fe_queue_v_i    = v;
      fe_queue_i      = d;
      fe_queue_yumi_i = yumi;
      fe_queue_clr_i  = clr;
      fe_queue_roll_i = roll;
      fe_queue_deq_i  = deq;
      model_step(v, d, yumi, clr, roll, deq);
      @(posedge clk);
      #1;
      fe_queue_v_i    = 1'b0;
      fe_queue_yumi_i = 1'b0;
      fe_queue_clr_i  = 1'b0;
      fe_queue_roll_i = 1'b0;
      fe_queue_deq_i  = 1'b0;
      check_model(tag);
   endtask

   task automatic do_reset();
      fe_queue_v_i    = 1'b0;
      fe_queue_i      = '0;
      fe_queue_yumi_i = 1'b0;
      fe_queue_clr_i  = 1'b0;
      fe_queue_roll_i = 1'b0;
      fe_queue_deq_i  = 1'b0;
      reset_n_i       = 1'b0;
      held.delete();
      issued = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n_i = 1'b1;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] pkt(input int tag);
      return W'(tag) ^ {W{1'b0}};
   endfunction

   typedef struct {
      logic         v;
      logic [W-1:0] d;
      logic         yumi;
      logic         deq;
      logic         e_ready;
      logic         e_v;
      logic         e_empty;
      logic [W-1:0] e_data;
   } vec_t;

   vec_t tbl[7];

   initial begin
      // Test 1 vectors: A, B, C enqueued and consumed, then three commits.
      tbl[0] = '{1'b1, pkt('hA), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, pkt('hA)};
      tbl[1] = '{1'b1, pkt('hB), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, pkt('hB)};
      tbl[2] = '{1'b1, pkt('hC), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, pkt('hC)};
      tbl[3] = '{1'b0, '0,       1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0};
      tbl[4] = '{1'b0, '0,       1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0};
      tbl[5] = '{1'b0, '0,       1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0};
      tbl[6] = '{1'b0, '0,       1'b0, 1'b1, 1'b1, 1'b0, 1'b1, '0};

      do_reset();
      check("reset.ready", 128'(fe_queue_ready_o), 128'(1));
      check("reset.v",     128'(fe_queue_v_o),     128'(0));
      check("reset.empty", 128'(empty_o),          128'(1));

      // Test 1
      for (int i = 0; i < 7; i++) begin
         string t;
         t = $sformatf("t1.%0d", i);
         cycle(t, tbl[i].v, tbl[i].d, tbl[i].yumi, 1'b0, 1'b0, tbl[i].deq);
         check({t, ".tbl_ready"}, 128'(fe_queue_ready_o), 128'(tbl[i].e_ready));
         check({t, ".tbl_v"},     128'(fe_queue_v_o),     128'(tbl[i].e_v));
         check({t, ".tbl_empty"}, 128'(empty_o),          128'(tbl[i].e_empty));
         if (tbl[i].e_v) check({t, ".tbl_data"}, 128'(fe_queue_o), 128'(tbl[i].e_data));
      end

      // Test 2: fill, full, deq frees a slot one cycle later, wrap into slot 0.
      do_reset();
      for (int i = 0; i < ELS; i++) cycle("t2.fill", 1'b1, pkt('h100 + i), 1'b0, 1'b0, 1'b0, 1'b0);
      check("t2.full_ready", 128'(fe_queue_ready_o), 128'(0));
      cycle("t2.rej17", 1'b1, pkt('h1FF), 1'b1, 1'b0, 1'b0, 1'b0);
      check("t2.rej17_data", 128'(fe_queue_o), 128'(pkt('h101)));
      cycle("t2.deq_enq", 1'b1, pkt('h1FF), 1'b0, 1'b0, 1'b0, 1'b1);
      check("t2.deq_ready", 128'(fe_queue_ready_o), 128'(1));
      cycle("t2.enq17", 1'b1, pkt('h1FF), 1'b0, 1'b0, 1'b0, 1'b0);
      check("t2.full2", 128'(fe_queue_ready_o), 128'(0));
      for (int i = 0; i < ELS - 1; i++) cycle("t2.drain", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("t2.wrap_data", 128'(fe_queue_o), 128'(pkt('h1FF)));

      // Test 3: replay after roll.
      do_reset();
      for (int i = 0; i < 5; i++) cycle("t3.enq", 1'b1, pkt('h30 + i), 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle("t3.yumi", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle("t3.deq", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle("t3.roll", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("t3.roll_v", 128'(fe_queue_v_o), 128'(1));
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("t3.replay%0d", i), 128'(fe_queue_o), 128'(pkt('h30 + i)));
         cycle("t3.ry", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      check("t3.done_v", 128'(fe_queue_v_o), 128'(0));

      // Test 4: roll + deq + yumi together with cptr=2, rptr=5.
      do_reset();
      for (int i = 0; i < 6; i++) cycle("t4.enq", 1'b1, pkt('h40 + i), 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cycle("t4.yumi", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) cycle("t4.deq", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle("t4.combo", 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
      check("t4.rptr3_data", 128'(fe_queue_o), 128'(pkt('h43)));
      for (int i = 0; i < 3; i++) cycle("t4.y", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle("t4.d", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t4.cptr_empty", 128'(empty_o), 128'(1));

      // Test 5: clr with a firing enqueue while 6 entries are held.
      do_reset();
      for (int i = 0; i < 6; i++) cycle("t5.enq", 1'b1, pkt('h50 + i), 1'b0, 1'b0, 1'b0, 1'b0);
      cycle("t5.yumi", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle("t5.clr", 1'b1, pkt('h5F), 1'b0, 1'b1, 1'b0, 1'b0);
      check("t5.empty", 128'(empty_o),          128'(1));
      check("t5.v",     128'(fe_queue_v_o),     128'(0));
      check("t5.ready", 128'(fe_queue_ready_o), 128'(1));
      cycle("t5.idle", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t5.idle_v", 128'(fe_queue_v_o), 128'(0));

      // Test 6: asynchronous reset mid-burst.
      do_reset();
      for (int i = 0; i < 3; i++) cycle("t6.enq", 1'b1, pkt('h60 + i), 1'b1 && (i > 0), 1'b0, 1'b0, 1'b0);
      fe_queue_v_i = 1'b1;
      fe_queue_i   = pkt('h6F);
      @(posedge clk);
      #2;
      reset_n_i = 1'b0;
      #1;
      check("t6.async_v",     128'(fe_queue_v_o),     128'(0));
      check("t6.async_empty", 128'(empty_o),          128'(1));
      check("t6.async_ready", 128'(fe_queue_ready_o), 128'(1));
      fe_queue_v_i = 1'b0;
      held.delete();
      issued = 0;
      @(negedge clk);
      reset_n_i = 1'b1;
      @(posedge clk);
      #1;
      cycle("t6.x", 1'b1, pkt('h6A), 1'b0, 1'b0, 1'b0, 1'b0);
      check("t6.x_data", 128'(fe_queue_o), 128'(pkt('h6A)));

      // Randomized traffic against the model; only legal yumi/deq are driven.
      do_reset();
      for (int n = 0; n < 2000; n++) begin
         logic [127:0] r;
         logic         v, y, c, ro, dq;
         r  = {$urandom, $urandom, $urandom, $urandom};
         v  = ($urandom_range(0, 99) < 60);
         c  = ($urandom_range(0, 99) < 2);
         ro = ($urandom_range(0, 99) < 5);
         y  = (issued < held.size()) && ($urandom_range(0, 99) < 50);
         dq = (issued > 0) && ($urandom_range(0, 99) < 40);
         cycle($sformatf("rnd%0d", n), v, r[W-1:0], y, c, ro, dq);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Global watchdog so the run always ends on its own.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
